// File: rtl/qam_demap_pkg.sv
// Shared types, Q4.12 slicer thresholds and the per-axis Gray mapping for the
// 16-QAM demapper and its carrier lock detector.
package qam_demap_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SYM_W    = 4;

  localparam logic signed [SAMPLE_W-1:0] THR_POS  = 16'sh2000;
  localparam logic signed [SAMPLE_W-1:0] THR_NEG  = 16'shE000;
  localparam logic signed [SAMPLE_W-1:0] THR_ZERO = 16'sh0000;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } lock_state_t;

  // Levels -3,-1,+1,+3 -> 00,01,11,10; a sample on a threshold takes the upper level.
  function automatic logic [1:0] grayMap(input logic signed [SAMPLE_W-1:0] x);
    logic [1:0] code;
    code = 2'b10;
    if (x < THR_NEG) begin
      code = 2'b00;
    end else if (x < THR_ZERO) begin
      code = 2'b01;
    end else if (x < THR_POS) begin
      code = 2'b11;
    end
    return code;
  endfunction

endpackage

// File: rtl/qam_lock_fsm.sv
// Carrier lock detector: windowed count of small phase errors feeding a
// SEARCH/VERIFY/LOCKED/HOLD state machine evaluated once per window.
module qam_lock_fsm
  import qam_demap_pkg::*;
#(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned PASS_CNT    = 56,
  parameter int unsigned LOCK_THR    = 1024,
  parameter int unsigned LOCK_WINS   = 2,
  parameter int unsigned UNLOCK_WINS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEnable,
  input  logic [15:0] phaseErr,
  output logic [1:0]  lockState,
  output logic        locked
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned GOOD_W = $clog2(WINDOW + 1);
  localparam int unsigned PASS_W = $clog2(LOCK_WINS + 1);
  localparam int unsigned FAIL_W = $clog2(UNLOCK_WINS + 1);

  lock_state_t       state, stateNext;
  logic [WIN_W-1:0]  winCnt;
  logic [GOOD_W-1:0] goodCnt, goodTotal;
  logic [PASS_W-1:0] passCnt, passNext, passInc;
  logic [FAIL_W-1:0] failCnt, failNext, failInc;
  logic [15:0]       absErr;
  logic              good, winEnd, winPass;

  // Magnitude with the most negative code folded onto full scale.
  always_comb begin
    absErr = phaseErr;
    if (phaseErr == 16'h8000) begin
      absErr = 16'h7FFF;
    end else if (phaseErr[15]) begin
      absErr = 16'(~phaseErr + 16'd1);
    end
  end

  assign good      = 32'(absErr) < LOCK_THR;
  assign winEnd    = clkEnable && (winCnt == WIN_W'(WINDOW - 1));
  assign goodTotal = goodCnt + GOOD_W'(good);
  assign winPass   = 32'(goodTotal) >= PASS_CNT;
  assign passInc   = (passCnt == PASS_W'(LOCK_WINS)) ? passCnt : passCnt + PASS_W'(1);
  assign failInc   = (failCnt == FAIL_W'(UNLOCK_WINS)) ? failCnt : failCnt + FAIL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      passCnt <= '0;
      failCnt <= '0;
      winCnt  <= '0;
      goodCnt <= '0;
      locked  <= 1'b0;
    end else begin
      locked <= (state == LOCKED) || (state == HOLD);
      if (clkEnable) begin
        winCnt  <= winEnd ? '0 : winCnt + WIN_W'(1);
        goodCnt <= winEnd ? '0 : goodTotal;
        state   <= stateNext;
        passCnt <= passNext;
        failCnt <= failNext;
      end
    end
  end

  always_comb begin
    stateNext = state;
    passNext  = passCnt;
    failNext  = failCnt;
    if (winEnd) begin
      case (state)
        SEARCH: begin
          if (winPass) begin
            passNext  = PASS_W'(1);
            stateNext = (LOCK_WINS <= 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (winPass) begin
            passNext = passInc;
            if (32'(passInc) >= LOCK_WINS) begin
              stateNext = LOCKED;
            end
          end else begin
            passNext  = '0;
            stateNext = SEARCH;
          end
        end
        LOCKED: begin
          if (!winPass) begin
            failNext  = FAIL_W'(1);
            stateNext = (UNLOCK_WINS <= 1) ? SEARCH : HOLD;
          end
        end
        HOLD: begin
          if (winPass) begin
            failNext  = '0;
            stateNext = LOCKED;
          end else begin
            failNext = failInc;
            if (32'(failInc) >= UNLOCK_WINS) begin
              stateNext = SEARCH;
            end
          end
        end
        default: stateNext = SEARCH;
      endcase
    end
  end

  assign lockState = state;

endmodule

// File: rtl/qam_demap_lock.sv
// 16-QAM hard-decision demapper (two-stage slicer pipeline) with a carrier
// lock indicator driven by the PLL phase error.
module qam_demap_lock
  import qam_demap_pkg::*;
#(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned PASS_CNT    = 56,
  parameter int unsigned LOCK_THR    = 1024,
  parameter int unsigned LOCK_WINS   = 2,
  parameter int unsigned UNLOCK_WINS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  input  logic [15:0] phase_err,
  output logic [3:0]  sym,
  output logic        sym_valid,
  output logic        locked,
  output logic [1:0]  lock_state
);

  logic [SAMPLE_W-1:0] reQ, imQ;
  logic                capValid;

  // Stage 1 captures the sample, stage 2 publishes its decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      reQ       <= '0;
      imQ       <= '0;
      capValid  <= 1'b0;
      sym       <= '0;
      sym_valid <= 1'b0;
    end else if (clk_enable) begin
      reQ       <= in_re;
      imQ       <= in_im;
      capValid  <= 1'b1;
      sym_valid <= capValid;
      if (capValid) begin
        sym <= {grayMap($signed(reQ)), grayMap($signed(imQ))};
      end
    end else begin
      sym_valid <= 1'b0;
    end
  end

  qam_lock_fsm #(
    .WINDOW      (WINDOW),
    .PASS_CNT    (PASS_CNT),
    .LOCK_THR    (LOCK_THR),
    .LOCK_WINS   (LOCK_WINS),
    .UNLOCK_WINS (UNLOCK_WINS)
  ) u_lockFsm (
    .clk       (clk),
    .reset     (reset),
    .clkEnable (clk_enable),
    .phaseErr  (phase_err),
    .lockState (lock_state),
    .locked    (locked)
  );

endmodule

// File: tb/tb_qam_demap_lock.sv
// Randomized self-checking bench for qam_demap_lock against an integer
// reference model of the slicer and the window-based lock rules.
module tb_qam_demap_lock;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic [15:0] phase_err = '0;
  logic [3:0]  sym;
  logic        sym_valid;
  logic        locked;
  logic [1:0]  lock_state;

  int total = 0;
  int bad   = 0;

  // Reference model state (defaults: WINDOW 64, PASS_CNT 56, THR 1024, 2 / 4 windows)
  int mSym = 0, mSymValid = 0, mLocked = 0, mState = 0;
  int mPassRun = 0, mFailRun = 0, mIdx = 0, mGood = 0;
  int mRe = 0, mIm = 0;
  bit mHave = 1'b0;

  always #5 clk = ~clk;

  qam_demap_lock dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in_re      (in_re),
    .in_im      (in_im),
    .phase_err  (phase_err),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .locked     (locked),
    .lock_state (lock_state)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toInt(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Decision level of one axis, as a real amplitude -3/-1/+1/+3 (units of 1.0).
  function automatic int levelOf(input int x);
    if (x < -8192) return -3;
    if (x < 0)     return -1;
    if (x < 8192)  return 1;
    return 3;
  endfunction

  function automatic int grayOf(input int lvl);
    int tbl [4];
    tbl = '{0, 1, 3, 2};
    return tbl[(lvl + 3) / 2];
  endfunction

  function automatic void windowEnd(input bit pass);
    case (mState)
      0: if (pass) begin mPassRun = 1; mState = (mPassRun >= 2) ? 2 : 1; end
      1: begin
        if (pass) begin
          mPassRun++;
          if (mPassRun >= 2) mState = 2;
        end else begin
          mPassRun = 0;
          mState = 0;
        end
      end
      2: if (!pass) begin mFailRun = 1; mState = 3; end
      default: begin
        if (pass) begin
          mFailRun = 0;
          mState = 2;
        end else begin
          mFailRun++;
          if (mFailRun >= 4) mState = 0;
        end
      end
    endcase
  endfunction

  function automatic void modelStep(input bit r, input bit e, input int re, input int im, input int pe);
    int mag;
    if (r) begin
      mSym = 0; mSymValid = 0; mLocked = 0; mState = 0;
      mPassRun = 0; mFailRun = 0; mIdx = 0; mGood = 0; mHave = 1'b0;
      return;
    end
    mLocked = (mState >= 2) ? 1 : 0;
    if (!e) begin
      mSymValid = 0;
      return;
    end
    mSymValid = mHave ? 1 : 0;
    if (mHave) mSym = grayOf(levelOf(mRe)) * 4 + grayOf(levelOf(mIm));
    mRe = re;
    mIm = im;
    mHave = 1'b1;
    mag = (pe < 0) ? -pe : pe;
    if (mag > 32767) mag = 32767;
    if (mag < 1024) mGood++;
    mIdx++;
    if (mIdx == 64) begin
      windowEnd(mGood >= 56);
      mIdx = 0;
      mGood = 0;
    end
  endfunction

  task automatic step(input bit r, input bit e, input logic [15:0] re, input logic [15:0] im,
                      input logic [15:0] pe);
    reset = r;
    clk_enable = e;
    in_re = re;
    in_im = im;
    phase_err = pe;
    @(posedge clk);
    modelStep(r, e, toInt(re), toInt(im), toInt(pe));
    @(negedge clk);
    checkVal("sym", int'(sym), mSym);
    checkVal("sym_valid", int'(sym_valid), mSymValid);
    checkVal("lock_state", int'(lock_state), mState);
    checkVal("locked", int'(locked), mLocked);
  endtask

  function automatic logic [15:0] pickSample();
    logic [15:0] t [8];
    t = '{16'h0000, 16'hE000, 16'h2000, 16'h1FFF, 16'hDFFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 3) == 0) return t[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  function automatic logic [15:0] goodErr();
    return 16'($urandom_range(0, 2046) - 1023);
  endfunction

  function automatic logic [15:0] badErr();
    logic [15:0] mag;
    case ($urandom_range(0, 4))
      0: return 16'd1024;
      1: return 16'hFC00;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: begin
        mag = 16'($urandom_range(1024, 32767));
        return $urandom_range(0, 1) ? mag : 16'(~mag + 16'd1);
      end
    endcase
  endfunction

  // Runs whole windows (aligned to the model's window position) with a random
  // good-sample count in [gLo,gHi] scattered over each window.
  task automatic runWindows(input int nWin, input int gLo, input int gHi, input int enPct);
    int done = 0;
    int goodN = $urandom_range(gLo, gHi);
    int off = $urandom_range(0, 63);
    bit e;
    logic [15:0] pe;
    while (done < nWin) begin
      e = ($urandom_range(0, 99) < enPct);
      pe = (((mIdx * 37 + off) % 64) < goodN) ? goodErr() : badErr();
      if (!e) pe = 16'($urandom);
      step(1'b0, e, pickSample(), pickSample(), pe);
      if (e && mIdx == 0) begin
        done++;
        goodN = $urandom_range(gLo, gHi);
        off = $urandom_range(0, 63);
      end
    end
  endtask

  task automatic enabledSamples(input int n, input logic [15:0] pe, input int enPct);
    int cnt = 0;
    bit e;
    while (cnt < n) begin
      e = ($urandom_range(0, 99) < enPct);
      step(1'b0, e, pickSample(), pickSample(), pe);
      if (e) cnt++;
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    checkVal("rst_sym", int'(sym), 0);
    checkVal("rst_state", int'(lock_state), 0);

    // First decision latency and the three tie points
    step(1'b0, 1'b1, 16'h3000, 16'hF000, 16'h0);
    checkVal("lat1_valid", int'(sym_valid), 0);
    step(1'b0, 1'b1, 16'h0000, 16'hE000, 16'h0);
    checkVal("first_sym", int'(sym), 4'b1001);
    checkVal("first_valid", int'(sym_valid), 1);
    step(1'b0, 1'b1, 16'h2000, 16'h1FFF, 16'h0);
    checkVal("tie_a_sym", int'(sym), 4'b1101);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    checkVal("idle_valid", int'(sym_valid), 0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    checkVal("tie_b_sym", int'(sym), 4'b1011);

    // Clean acquisition from reset: VERIFY at sample 64, LOCKED at 128
    step(1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
    enabledSamples(63, 16'h0, 100);
    checkVal("acq63_state", int'(lock_state), 0);
    enabledSamples(1, 16'h0, 100);
    checkVal("acq64_state", int'(lock_state), 1);
    enabledSamples(64, 16'h0, 100);
    checkVal("acq128_state", int'(lock_state), 2);
    checkVal("acq128_locked", int'(locked), 0);
    enabledSamples(1, 16'h0, 100);
    checkVal("acq129_locked", int'(locked), 1);

    // Loss of lock through HOLD, including a recovery from HOLD
    runWindows(1, 0, 0, 100);
    checkVal("hold_state", int'(lock_state), 3);
    runWindows(1, 64, 64, 100);
    checkVal("relock_state", int'(lock_state), 2);
    enabledSamples(64 - mIdx, 16'h8000, 80);
    checkVal("fail1_state", int'(lock_state), 3);
    runWindows(2, 0, 20, 80);
    checkVal("fail3_state", int'(lock_state), 3);
    runWindows(1, 0, 0, 80);
    checkVal("fail4_state", int'(lock_state), 0);
    checkVal("fail4_locked", int'(locked), 1);

    // Pass threshold boundary: 56 passes, 55 fails
    step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    runWindows(1, 56, 56, 100);
    checkVal("pass56_state", int'(lock_state), 1);
    runWindows(1, 55, 55, 100);
    checkVal("fail55_state", int'(lock_state), 0);
    runWindows(2, 56, 56, 70);
    checkVal("two56_state", int'(lock_state), 2);

    // Random mix of window qualities and enable duty
    runWindows(12, 50, 64, 75);
    runWindows(8, 54, 58, 60);
    runWindows(8, 0, 64, 90);

    // Reset in the middle of a VERIFY window with the enable toggling
    step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    runWindows(1, 64, 64, 100);
    enabledSamples(30, 16'h0, 60);
    checkVal("mid_pre_state", int'(lock_state), 1);
    step(1'b1, 1'b1, 16'h3000, 16'h3000, 16'h0);
    checkVal("mid_rst_sym", int'(sym), 0);
    checkVal("mid_rst_valid", int'(sym_valid), 0);
    checkVal("mid_rst_state", int'(lock_state), 0);
    checkVal("mid_rst_locked", int'(locked), 0);
    step(1'b1, 1'b0, 16'h3000, 16'h3000, 16'h0);
    enabledSamples(63, 16'h0, 60);
    checkVal("post_rst63_state", int'(lock_state), 0);
    enabledSamples(1, 16'h0, 60);
    checkVal("post_rst64_state", int'(lock_state), 1);
    runWindows(4, 40, 64, 75);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
